req_encoder_hs: RTL and testbench
=================================

// Module: req_encoder_hs
// PURPOSE
//  Parametrised successor to the 8:3 encoder: N request lines latched into a sticky pending register.
//  Index of the selected pending line is offered on a registered valid/ready output.
//  Selection is fixed-priority or round-robin. Sits between request sources (IRQ/event lines) and a consumer FSM.
// PARAMETERS
//  N      8                  number of request lines (2..64)
//  IDX_W  $clog2(N)          width of encoded index
//  MODE   0                  0 = fixed priority (highest index wins), 1 = round-robin
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous active-low reset
//  clr       in   1      synchronous flush of pending/offer state
//  req       in   N      level requests; bit i high in a cycle sets pending[i]
//  enc_idx   out  IDX_W  encoded index of offered request (registered)
//  enc_valid out  1      offer valid (registered)
//  enc_ready in   1      consumer accept; transfer when enc_valid && enc_ready
//  pending   out  N      sticky pending vector (registered)
//  overrun   out  1      1-cycle pulse: a req bit hit an already-pending bit not being accepted this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): pending=0, enc_valid=0, enc_idx=0, overrun=0, rr_ptr=N-1.
//  Pending update per edge:
//    pending_next = (pending & ~acc_onehot) | req
//    acc_onehot = decode(enc_idx) when enc_valid && enc_ready, else 0.
//    Set wins: req[i] in the accept cycle of i re-pends i.
//  Selection source: sel_vec = pending_next.
//    Pick is made from the value being registered, so new requests are seen immediately.
//  FSM, 2 states:
//    IDLE  (enc_valid=0): if sel_vec!=0 -> OFFER, load enc_idx=pick(sel_vec).
//    OFFER (enc_valid=1): enc_idx/enc_valid frozen while !enc_ready.
//      On accept: if sel_vec!=0, stay OFFER and load the next pick (back-to-back, no bubble); else -> IDLE.
//  Latency: req[i] high in cycle k -> pending[i]=1 and enc_valid=1 after edge k (one-cycle latency from idle).
//  Fixed pick (MODE=0): highest set index of sel_vec.
//  RR pick (MODE=1): first set index searching upward from rr_ptr+1, wrapping mod N.
//    rr_ptr <= enc_idx on each accept only.
//  Overrun: overrun=1 for one cycle when any i has req[i] && pending[i] && !acc_onehot[i]. No state change; request merges.
//  clr: next edge pending=0, enc_valid=0, enc_idx=0, rr_ptr=N-1.
//    clr overrides req and accept in the same cycle; overrun=0.
//  Reset mid-offer: offer dropped immediately (async). No transfer counts.
//  enc_idx is don't-care-stable (held at last value) while enc_valid=0.
//  N not a power of 2: indices >= N never produced. Wrap uses N, not 2^IDX_W.
// STRUCTURE
//  Package enc_pkg: MODE_FIXED=0, MODE_RR=1 localparams; function onehot_decode(idx,N).
//  Sub-module prio_pick (combinational): inputs vec[N], base[IDX_W], rr_en.
//    Outputs idx[IDX_W], any. Rotate-by-base, find-first, un-rotate.
//  Top holds pending reg, offer FSM, rr_ptr, overrun flop.
// TESTING (N=8)
//  MODE=0, req=8'b1000_0010 one cycle, enc_ready=1 -> idx 7 then idx 1 on consecutive cycles, then valid=0.
//  MODE=0, req=8'h04 held, enc_ready=0 for 5 cycles -> idx=2 valid stable, overrun pulses each cycle after the first.
//  MODE=1, req=8'hFF one cycle, enc_ready=1 -> idx 0,1,...,7 in order.
//    Then req=8'h81 -> idx 0 then 7 (ptr wrap).
//  Accept idx 3 while req[3]=1 same cycle -> pending[3] stays 1, next offer is idx 3 again (set wins).
//  Offer idx 5 pending, assert clr with req=8'h01 -> next cycle valid=0, pending=0, overrun=0.
//  Async rst_n low mid-offer (between edges) -> enc_valid=0, pending=0 immediately.
//    After release, MODE=1 first pick from 8'h30 is 4.

Source files
------------

// File: rtl/req_encoder_hs_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the request encoder:
//   MODE_FIXED / MODE_RR : selection-mode values for the MODE parameter
//   enc_state_t          : offer FSM state encoding
//   onehot_decode()      : index -> one-hot vector (up to 64 lines)
// ---------------------------------------------------------------------------
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_t;

    // Returns a 64-bit one-hot of idx; indices at or beyond n give all-zero,
    // so callers can slice the low n bits without a range check.
    function automatic logic [63:0] onehot_decode(input int unsigned idx,
                                                  input int unsigned n);
        logic [63:0] v;
        v = '0;
        if (idx < n) begin
            v = 64'd1 << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/req_encoder_hs_prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Combinational picker over an N-bit request vector.
//   vec   in  N      candidate lines
//   base  in  IDX_W  round-robin pointer (last granted index)
//   rr_en in  1      0: highest set index wins, 1: first set index above base
//   idx   out IDX_W  selected index (0 when nothing is set)
//   any   out 1      at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_pick #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] base,
    input  logic             rr_en,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Wraps base+offset back into 0..N-1. The wrap is on N, not 2^IDX_W,
    // so indices >= N are never produced for non-power-of-two N.
    function automatic int wrap_idx(input int j);
        return (j >= N) ? (j - N) : j;
    endfunction

    always_comb begin
        idx = '0;
        any = |vec;
        if (rr_en) begin
            // Rotated search: offsets base+1 .. base+N. Scanning from the far
            // end toward the near end lets the nearest set bit overwrite the
            // result, which is the un-rotated find-first.
            for (int k = N; k >= 1; k--) begin
                if (vec[wrap_idx(int'(base) + k)]) begin
                    idx = IDX_W'(wrap_idx(int'(base) + k));
                end
            end
        end else begin
            // Ascending scan: the last set bit seen is the highest index.
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/req_encoder_hs.sv
// ---------------------------------------------------------------------------
// req_encoder_hs
// Latches N level request lines into a sticky pending register and offers
// the index of one pending line on a registered valid/ready output.
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   clr       in   1      synchronous flush of pending/offer/pointer state
//   req       in   N      level requests, each high cycle sets pending[i]
//   enc_idx   out  IDX_W  offered index (held while enc_valid=0)
//   enc_valid out  1      offer valid
//   enc_ready in   1      consumer accept
//   pending   out  N      sticky pending vector
//   overrun   out  1      one-cycle pulse when a request hits an already
//                         pending line that is not being accepted
//
// Handshake: a transfer happens on a rising edge where enc_valid and
// enc_ready are both high. While enc_valid is high and enc_ready is low,
// enc_idx and enc_valid do not change. enc_ready may be high at any time.
// ---------------------------------------------------------------------------
module req_encoder_hs
    import enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int MODE  = MODE_FIXED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] enc_idx,
    output logic             enc_valid,
    input  logic             enc_ready,
    output logic [N-1:0]     pending,
    output logic             overrun
);

    localparam logic [IDX_W-1:0] RR_INIT = IDX_W'(N - 1);

    enc_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] rr_ptr, rr_d;
    logic [N-1:0]     pending_d;
    logic             overrun_d;

    logic             accept;
    logic [63:0]      dec_full;
    logic [N-1:0]     acc_onehot;
    logic [N-1:0]     pending_next;
    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign enc_valid = (state_q == OFFER);
    assign accept    = enc_valid && enc_ready;

    assign dec_full   = onehot_decode(int'(enc_idx), N);
    assign acc_onehot = accept ? dec_full[N-1:0] : '0;

    // Clear the accepted line, then OR in new requests: a request on the
    // line being accepted in the same cycle re-pends it.
    assign pending_next = (pending & ~acc_onehot) | req;

    // On an accept the pointer is about to become enc_idx; use that value
    // now so a back-to-back pick already rotates past the granted line.
    assign pick_base = accept ? enc_idx : rr_ptr;

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec   (pending_next),
        .base  (pick_base),
        .rr_en (MODE == MODE_RR),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = enc_idx;
        rr_d      = rr_ptr;
        pending_d = pending_next;
        overrun_d = |(req & pending & ~acc_onehot);

        if (accept) begin
            rr_d = enc_idx;
        end

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = OFFER;
                    idx_d   = pick_idx;
                end
            end
            OFFER: begin
                if (accept) begin
                    if (pick_any) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush dominates requests and accepts arriving in the same cycle.
        if (clr) begin
            state_d   = IDLE;
            idx_d     = '0;
            rr_d      = RR_INIT;
            pending_d = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            enc_idx <= '0;
            rr_ptr  <= RR_INIT;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            enc_idx <= idx_d;
            rr_ptr  <= rr_d;
            pending <= pending_d;
            overrun <= overrun_d;
        end
    end

endmodule

// File: tb/tb_req_encoder_hs.sv
// ---------------------------------------------------------------------------
// tb_req_encoder_hs
// Drives one fixed-priority and one round-robin instance (N=8) with directed
// vectors. Expected transfer indices are queued as stimulus is issued and a
// negedge monitor pops them on every valid&&ready; register state is checked
// directly just after the active edge.
// ---------------------------------------------------------------------------
module tb_req_encoder_hs;
    import enc_pkg::*;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             f_clr, f_ready, f_valid, f_overrun;
    logic [N-1:0]     f_req, f_pending;
    logic [IDX_W-1:0] f_idx;
    logic             r_clr, r_ready, r_valid, r_overrun;
    logic [N-1:0]     r_req, r_pending;
    logic [IDX_W-1:0] r_idx;

    req_encoder_hs #(.N(N), .IDX_W(IDX_W), .MODE(MODE_FIXED)) dut_f (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (f_clr),
        .req       (f_req),
        .enc_idx   (f_idx),
        .enc_valid (f_valid),
        .enc_ready (f_ready),
        .pending   (f_pending),
        .overrun   (f_overrun)
    );

    req_encoder_hs #(.N(N), .IDX_W(IDX_W), .MODE(MODE_RR)) dut_r (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (r_clr),
        .req       (r_req),
        .enc_idx   (r_idx),
        .enc_valid (r_valid),
        .enc_ready (r_ready),
        .pending   (r_pending),
        .overrun   (r_overrun)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [IDX_W-1:0] exp_q_f[$];
    logic [IDX_W-1:0] exp_q_r[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer is decided by the values seen half a cycle
    // before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n && f_valid && f_ready) begin
            if (exp_q_f.size() == 0) begin
                check("f_unexpected_transfer", 64'(f_idx), 64'hDEAD);
            end else begin
                check("f_transfer_idx", 64'(f_idx), 64'(exp_q_f.pop_front()));
            end
        end
        if (rst_n && r_valid && r_ready) begin
            if (exp_q_r.size() == 0) begin
                check("r_unexpected_transfer", 64'(r_idx), 64'hDEAD);
            end else begin
                check("r_transfer_idx", 64'(r_idx), 64'(exp_q_r.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        f_clr   = 1'b0; f_req = '0; f_ready = 1'b0;
        r_clr   = 1'b0; r_req = '0; r_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("f_reset_pending", 64'(f_pending), 64'h0);
        check("f_reset_valid",   64'(f_valid),   64'h0);
        check("f_reset_idx",     64'(f_idx),     64'h0);
        check("f_reset_overrun", 64'(f_overrun), 64'h0);
        check("r_reset_valid",   64'(r_valid),   64'h0);
        #2 rst_n = 1'b1;

        // Fixed priority: two lines in one cycle drain highest first
        exp_q_f.push_back(3'd7);
        exp_q_f.push_back(3'd1);
        f_req   = 8'b1000_0010;
        f_ready = 1'b1;
        tick();
        check("f_hp_valid1",   64'(f_valid),   64'h1);
        check("f_hp_idx1",     64'(f_idx),     64'h7);
        check("f_hp_pending1", 64'(f_pending), 64'h82);
        f_req = '0;
        tick();
        check("f_hp_idx2",     64'(f_idx),     64'h1);
        check("f_hp_pending2", 64'(f_pending), 64'h02);
        tick();
        check("f_hp_valid_end",   64'(f_valid),   64'h0);
        check("f_hp_pending_end", 64'(f_pending), 64'h0);

        // Held request under backpressure: offer stable, overrun after first
        f_ready = 1'b0;
        f_req   = 8'h04;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("f_bp_valid",   64'(f_valid),   64'h1);
            check("f_bp_idx",     64'(f_idx),     64'h2);
            check("f_bp_overrun", 64'(f_overrun), (c == 0) ? 64'h0 : 64'h1);
        end
        f_req   = '0;
        f_ready = 1'b1;
        exp_q_f.push_back(3'd2);
        tick();
        check("f_bp_valid_end",   64'(f_valid),   64'h0);
        check("f_bp_overrun_end", 64'(f_overrun), 64'h0);

        // Set wins over accept on the same line
        f_ready = 1'b0;
        f_req   = 8'h08;
        tick();
        check("f_sw_idx", 64'(f_idx), 64'h3);
        f_ready = 1'b1;
        exp_q_f.push_back(3'd3);
        tick();
        check("f_sw_pending", 64'(f_pending), 64'h08);
        check("f_sw_valid",   64'(f_valid),   64'h1);
        check("f_sw_idx2",    64'(f_idx),     64'h3);
        check("f_sw_overrun", 64'(f_overrun), 64'h0);
        f_req = '0;
        exp_q_f.push_back(3'd3);
        tick();
        check("f_sw_valid_end", 64'(f_valid), 64'h0);

        // Flush during an offer; the new request (incl. a would-be overrun
        // on line 5) is discarded
        f_ready = 1'b0;
        f_req   = 8'h20;
        tick();
        check("f_clr_pre_idx", 64'(f_idx), 64'h5);
        f_clr = 1'b1;
        f_req = 8'h21;
        tick();
        check("f_clr_valid",   64'(f_valid),   64'h0);
        check("f_clr_pending", 64'(f_pending), 64'h0);
        check("f_clr_overrun", 64'(f_overrun), 64'h0);
        check("f_clr_idx",     64'(f_idx),     64'h0);
        f_clr = 1'b0;
        f_req = '0;

        // Round-robin: all lines in one cycle come out in ascending order
        r_ready = 1'b1;
        for (int i = 0; i < N; i++) exp_q_r.push_back(IDX_W'(i));
        r_req = 8'hFF;
        tick();
        check("r_all_first_idx", 64'(r_idx), 64'h0);
        r_req = '0;
        repeat (N) tick();
        check("r_all_valid_end", 64'(r_valid), 64'h0);

        // Pointer sits at 7: lines 0 and 7 -> 0 first, then 7
        exp_q_r.push_back(3'd0);
        exp_q_r.push_back(3'd7);
        r_req = 8'h81;
        tick();
        check("r_wrap_idx1", 64'(r_idx), 64'h0);
        r_req = '0;
        tick();
        check("r_wrap_idx2", 64'(r_idx), 64'h7);
        tick();
        check("r_wrap_valid_end", 64'(r_valid), 64'h0);

        // Asynchronous reset between edges drops a live offer
        r_ready = 1'b0;
        r_req   = 8'h04;
        tick();
        check("r_rst_pre_valid", 64'(r_valid), 64'h1);
        r_req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("r_rst_valid",   64'(r_valid),   64'h0);
        check("r_rst_pending", 64'(r_pending), 64'h0);
        tick();
        #2 rst_n = 1'b1;

        // Pointer back at 7 after reset: from 0x30 the first pick is 4
        exp_q_r.push_back(3'd4);
        exp_q_r.push_back(3'd5);
        r_req   = 8'h30;
        r_ready = 1'b1;
        tick();
        check("r_post_rst_idx", 64'(r_idx), 64'h4);
        r_req = '0;
        tick();
        tick();
        check("r_post_rst_valid_end", 64'(r_valid), 64'h0);

        repeat (3) tick();
        check("f_queue_drained", 64'(exp_q_f.size()), 64'h0);
        check("r_queue_drained", 64'(exp_q_r.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
